// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types for the CPU step controller: FSM state encoding and run-rate limits.
package cpu_step_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [1:0] RATE_SLOW = 2'd0;
   localparam logic [1:0] RATE_FAST = 2'd3;

   // Prescaler bits ignored by the tick compare: each rate step divides the period by 4.
   function automatic logic [2:0] rate_shift(input logic [1:0] rate);
      return {rate, 1'b0};
   endfunction

endpackage

// File: rtl/cpu_step_ctrl_key_debounce.sv
// Step-button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// press pulse on each accepted 1->0 change of the debounced level.
module key_debounce #(
   parameter int DEB_CYC = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

   logic          sync1_q, sync2_q;
   logic          key_db_q, key_db_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synced level disagrees with the accepted one,
   // so any bounce back to the accepted level restarts the qualification window.
   always_comb begin
      key_db_d = key_db_q;
      cnt_d    = cnt_q;
      press_d  = 1'b0;
      if (sync2_q == key_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         key_db_d = sync2_q;
         cnt_d    = '0;
         press_d  = key_db_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         key_db_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= key_n;
         sync2_q  <= sync1_q;
         key_db_q <= key_db_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU advance-enable generator: free-run from a prescaler, single-step from the
// debounced button, or hold; cpu_en is a one-clk pulse consumed by the core.
module cpu_step_ctrl
   import cpu_step_pkg::*;
#(
   parameter int DIV_W   = 26,
   parameter int DEB_CYC = 500000,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode_run,
   input  logic             key_n,
   input  logic [1:0]       rate,
   input  logic             halt,
   output logic             cpu_en,
   output logic             led_tick,
   output logic [CNT_W-1:0] step_count,
   output logic [1:0]       state
);

   logic             mode_s1_q, mode_s2_q;
   logic             press;
   logic             tick;
   logic             cpu_en_c;
   state_t           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             led_q, led_d;

   function automatic logic [DIV_W-1:0] run_mask(input logic [1:0] r);
      return {DIV_W{1'b1}} >> rate_shift(r);
   endfunction

   key_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_key_debounce (
      .clk   (clk),
      .reset (reset),
      .key_n (key_n),
      .press (press)
   );

   // mode_run is a slow switch; synchronising it is enough, no debounce needed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_s1_q <= 1'b0;
         mode_s2_q <= 1'b0;
      end else begin
         mode_s1_q <= mode_run;
         mode_s2_q <= mode_s1_q;
      end
   end

   assign tick     = &(presc_q | ~run_mask(rate));
   assign cpu_en_c = (state_q == STEP) ||
                     ((state_q == RUN) && tick && !halt && mode_s2_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mode_s2_q)          state_d = RUN;
            else if (press && !halt) state_d = STEP;
         end
         STEP:   state_d = IDLE;
         RUN: begin
            if (halt)            state_d = HALTED;
            else if (!mode_s2_q) state_d = IDLE;
         end
         HALTED: begin
            if (!halt && !mode_s2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler only counts while in RUN, so every RUN entry starts a fresh period.
   always_comb begin
      presc_d = (state_q == RUN) ? presc_q + 1'b1 : '0;
      cnt_d   = cpu_en_c ? cnt_q + 1'b1 : cnt_q;
      led_d   = cpu_en_c ? ~led_q : led_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
      end
   end

   assign cpu_en     = cpu_en_c;
   assign led_tick   = led_q;
   assign step_count = cnt_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected pulse cycles are queued when stimulus
// is applied and matched against cpu_en by a negedge monitor.
module tb_cpu_step_ctrl;

   localparam int DIV_W   = 8;
   localparam int DEB_CYC = 4;
   localparam int CNT_W   = 4;
   localparam int KEY_LAT = DEB_CYC + 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             mode_run;
   logic             key_n;
   logic [1:0]       rate;
   logic             halt;
   logic             cpu_en;
   logic             led_tick;
   logic [CNT_W-1:0] step_count;
   logic [1:0]       state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_cnt  = 0;
   int exp_q[$];
   int mon_e;

   cpu_step_ctrl #(
      .DIV_W   (DIV_W),
      .DEB_CYC (DEB_CYC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode_run   (mode_run),
      .key_n      (key_n),
      .rate       (rate),
      .halt       (halt),
      .cpu_en     (cpu_en),
      .led_tick   (led_tick),
      .step_count (step_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cpu_en !== 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pulse_unexpected cyc=%0d actual=%b required=0", cyc, cpu_en);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e != cyc) begin
               failures++;
               $display("FAIL pulse_cycle actual=%0d required=%0d", cyc, mon_e);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0] == cyc) begin
         checks++;
         failures++;
         mon_e = exp_q.pop_front();
         $display("FAIL pulse_missing cyc=%0d actual=0 required=1", mon_e);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick_n(1);
   endtask

   task automatic test_reset();
      int c;
      reset = 1'b1; mode_run = 1'b0; key_n = 1'b1; rate = 2'd0; halt = 1'b0;
      tick_n(3);
      checks++;
      if ({cpu_en, led_tick, step_count, state} !== '0) begin
         failures++;
         $display("FAIL reset_state actual=%b%b_%h_%0d required=0", cpu_en, led_tick, step_count, state);
      end
      reset = 1'b0;
      tick_n(2);
      c = cyc;
      mode_run = 1'b1; rate = 2'd3;
      exp_q.push_back(c + 6); exp_q.push_back(c + 10); exp_q.push_back(c + 14);
      wait_until(c + 15);
      checks++;
      if (step_count !== 4'd3 || led_tick !== 1'b1) begin
         failures++;
         $display("FAIL run_before_reset actual=%0d/%b required=3/1", step_count, led_tick);
      end
      #2;
      reset = 1'b1; mode_run = 1'b0;
      #1;
      checks++;
      if (cpu_en !== 1'b0 || led_tick !== 1'b0 || step_count !== 4'd0 || state !== 2'd0) begin
         failures++;
         $display("FAIL async_reset actual=%b%b_%h_%0d required=0", cpu_en, led_tick, step_count, state);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL reset_queue actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
      tick_n(3);
   endtask

   task automatic test_step_hold();
      int c;
      c = cyc;
      key_n = 1'b0;
      exp_q.push_back(c + KEY_LAT);
      exp_cnt++;
      wait_until(c + 20);
      checks++;
      if (step_count !== CNT_W'(exp_cnt) || led_tick !== 1'b1 || state !== 2'd0) begin
         failures++;
         $display("FAIL step_hold actual=%0d/%b/%0d required=%0d/1/0", step_count, led_tick, state, exp_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL step_hold_pending actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      key_n = 1'b1;
      tick_n(12);
   endtask

   task automatic test_bounce();
      int c;
      c = cyc;
      exp_q.push_back(c + 8 + KEY_LAT);
      exp_cnt++;
      for (int i = 0; i < 5; i++) begin
         key_n = (i % 2 == 1);
         tick_n(2);
      end
      wait_until(c + 25);
      checks++;
      if (step_count !== CNT_W'(exp_cnt) || led_tick !== 1'b0) begin
         failures++;
         $display("FAIL bounce_count actual=%0d/%b required=%0d/0", step_count, led_tick, exp_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL bounce_pending actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      key_n = 1'b1;
      tick_n(12);
   endtask

   task automatic test_run_rate(input int r);
      int c;
      int p;
      p = 1 << (DIV_W - 2 * r);
      c = cyc;
      mode_run = 1'b1; rate = 2'(r);
      for (int k = 1; k <= 10; k++) exp_q.push_back(c + 2 + p * k);
      exp_cnt += 10;
      wait_until(c + 2 + 10 * p);
      mode_run = 1'b0;
      tick_n(6);
      checks++;
      if (state !== 2'd0 || step_count !== CNT_W'(exp_cnt) || led_tick !== 1'(exp_cnt % 2)) begin
         failures++;
         $display("FAIL run_rate%0d actual=%0d/%0d/%b required=0/%0d/%0d", r, state, step_count, led_tick, exp_cnt % 16, exp_cnt % 2);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL run_rate%0d_pending actual=%0d required=0", r, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_halt();
      int c;
      c = cyc;
      mode_run = 1'b1; rate = 2'd3;
      exp_q.push_back(c + 6); exp_q.push_back(c + 10);
      exp_cnt += 2;
      wait_until(c + 14);
      halt = 1'b1;
      tick_n(1);
      checks++;
      if (state !== 2'd3) begin
         failures++;
         $display("FAIL halt_enter actual=%0d required=3", state);
      end
      halt = 1'b0;
      tick_n(6);
      checks++;
      if (state !== 2'd3) begin
         failures++;
         $display("FAIL halt_hold actual=%0d required=3", state);
      end
      mode_run = 1'b0;
      tick_n(4);
      checks++;
      if (state !== 2'd0 || step_count !== CNT_W'(exp_cnt)) begin
         failures++;
         $display("FAIL halt_exit actual=%0d/%0d required=0/%0d", state, step_count, exp_cnt);
      end
      halt = 1'b1; key_n = 1'b0;
      tick_n(12);
      key_n = 1'b1; halt = 1'b0;
      tick_n(10);
      checks++;
      if (step_count !== CNT_W'(exp_cnt) || exp_q.size() != 0) begin
         failures++;
         $display("FAIL halt_press_drop actual=%0d/%0d required=%0d/0", step_count, exp_q.size(), exp_cnt);
         exp_q.delete();
      end
   endtask

   task automatic test_wrap();
      int c;
      reset = 1'b1;
      tick_n(2);
      reset = 1'b0;
      exp_cnt = 0;
      tick_n(2);
      for (int s = 0; s < 17; s++) begin
         c = cyc;
         key_n = 1'b0;
         exp_q.push_back(c + KEY_LAT);
         exp_cnt++;
         wait_until(c + KEY_LAT + 2);
         checks++;
         if (step_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL wrap_step%0d actual=%0d required=%0d", s, step_count, exp_cnt % 16);
         end
         key_n = 1'b1;
         tick_n(10);
      end
      checks++;
      if (step_count !== 4'd1 || led_tick !== 1'b1) begin
         failures++;
         $display("FAIL wrap_final actual=%0d/%b required=1/1", step_count, led_tick);
      end
      mode_run = 1'b1; rate = 2'd0;
      tick_n(4);
      key_n = 1'b0;
      tick_n(12);
      key_n = 1'b1;
      tick_n(10);
      mode_run = 1'b0;
      tick_n(5);
      checks++;
      if (step_count !== 4'd1 || state !== 2'd0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL run_press_drop actual=%0d/%0d/%0d required=1/0/0", step_count, state, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_step_hold();
      test_bounce();
      test_run_rate(0);
      test_run_rate(3);
      test_halt();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
